add_sub_btn_conditioner: RTL
============================

ADD_SUB_BTN_CONDITIONER -- requirements
Module: add_sub_btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable synchronized samples needed to accept a button change (5 ms at 100 MHz); legal range 2 to 2^24-1.
REQ-002 Parameter REPEAT_DELAY, default 50000000: cycles in HELD before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 10000000: cycles between later auto-repeat pulses.
REQ-004 clk  input  1: single clock; all state on its rising edge.
REQ-005 rst_n  input  1: asynchronous active-low reset.
REQ-006 sw  input  16: raw switches; [15:8] operand A, [7:0] operand B.
REQ-007 btnl  input  1: raw clear button.
REQ-008 btnr  input  1: raw subtract button.
REQ-009 sw_sync  output  16: sw after a two-flop synchronizer.
REQ-010 btnl_level, btnr_level  output  1 each: debounced button levels that feed the adder stage.
REQ-011 btnl_press, btnr_press  output  1 each: one-cycle pulse per accepted press, plus auto-repeat pulses when enabled.

Function
REQ-012 Each button SHALL pass through a two-flop synchronizer before it reaches its debounce FSM.
REQ-013 Each FSM SHALL use four states: IDLE (released), PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-014 IDLE->PRESS_WAIT on synchronized 1; HELD->RELEASE_WAIT on synchronized 0; entering a wait state SHALL clear the stability counter.
REQ-015 PRESS_WAIT->HELD when the DEBOUNCE_CYCLES-th consecutive synchronized 1 is sampled; a synchronized 0 before that SHALL return to IDLE with no output change.
REQ-016 RELEASE_WAIT->IDLE on the DEBOUNCE_CYCLES-th consecutive synchronized 0; a synchronized 1 before that SHALL return to HELD with no pulse.
REQ-017 Level SHALL be 1 in HELD and RELEASE_WAIT and 0 otherwise. The press pulse SHALL assert only in the cycle after PRESS_WAIT->HELD.
REQ-018 Latency: for a clean raw edge, level and pulse SHALL change exactly 2+DEBOUNCE_CYCLES cycles after the first cycle the raw input is sampled high.
REQ-019 The two channels SHALL be fully independent; simultaneous presses SHALL give both pulses in the same cycle.
REQ-020 The stability counter SHALL saturate and never wrap. sw_sync SHALL have a fixed 2-cycle latency with no debounce.

Reset
REQ-021 Asserting rst_n low SHALL, at any time including mid-wait, force both FSMs to IDLE, zero all counters and synchronizer flops, and drive every output to 0.
REQ-022 After rst_n is released, a button already held SHALL be treated as a new press: a full debounce, then one pulse.

Configuration
REQ-023 When BTN_AUTOREPEAT_EN is defined, a channel in HELD SHALL emit a press pulse REPEAT_DELAY cycles after entering HELD and then every REPEAT_PERIOD cycles. RELEASE_WAIT SHALL pause the repeat counter, and a return to HELD SHALL resume it.
REQ-024 When BTN_AUTOREPEAT_EN is undefined, no repeat counter SHALL exist and each accepted press SHALL give exactly one pulse.

Structure
REQ-025 Shared package add_sub_pkg SHALL hold the debounce state enum and the default values of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-026 One sub-module, btn_debounce_ch, SHALL hold the synchronizer, FSM, counters and pulse logic for one button; it SHALL be instantiated twice (btnl, btnr).

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-027 Clean press: btnr 0->1 and held -> btnr_level=1 and a single btnr_press pulse exactly 6 cycles later; btnl outputs stay 0.
REQ-028 Bounce: btnl pattern 1,0,1,1,0 then steady 1 -> no output until 4 consecutive synchronized 1s, then exactly one btnl_press.
REQ-029 Release glitch: while held, btnr low for 2 cycles then high -> btnr_level stays 1 and no new pulse.
REQ-030 Reset mid-wait: rst_n low in PRESS_WAIT -> all outputs 0 at once. Release with button still held -> pulse 6 cycles after reset release.
REQ-031 Auto-repeat (macro defined): btnl held 50 cycles after acceptance -> repeat pulses at 20, 28, 36, 44 cycles after HELD entry. Macro undefined -> only the initial pulse.
REQ-032 Switches: sw=16'hA55A -> sw_sync=16'hA55A two cycles later; simultaneous btnl/btnr presses -> both pulses in the same cycle.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types and defaults for the add/sub board button and switch conditioner.
// The optional auto-repeat feature is enabled by defining BTN_AUTOREPEAT_EN.
package add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } dbnc_state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned REPEAT_DELAY_DEF    = 50000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 10000000;

    localparam int unsigned CNT_W = 24;
    localparam int unsigned RPT_W = 32;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/add_sub_btn_conditioner_debounce_ch.sv
// One button channel: 2-flop synchronizer, 4-state debounce FSM, press pulse and
// optional auto-repeat (BTN_AUTOREPEAT_EN).
module btn_debounce_ch
    import add_sub_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    // The sample that enters a wait state is the first stable one, so the
    // counter only has to cover the remaining DEBOUNCE_CYCLES-1 samples.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_debounce_ch: illegal timing parameter");
    end

    logic [1:0]       sync_q, sync_d;
    dbnc_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             btn_s;

    assign btn_s = sync_q[1];

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0] rpt_inc;
    logic [RPT_W-1:0] rpt_target;
    assign rpt_inc    = rpt_q + RPT_W'(1);
    assign rpt_target = rpt_first_q ? RPT_DELAY : RPT_PERIOD;
`endif

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    rpt_d       = '0;
                    rpt_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = sat_inc_cnt(cnt_q);
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (rpt_inc >= rpt_target) begin
                        press_d     = 1'b1;
                        rpt_d       = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_d = rpt_inc;
                    end
`endif
                end
            end
            ST_RELEASE_WAIT: begin
                // Repeat counter is left untouched here so a glitch only pauses it.
                if (btn_s) begin
                    state_d = ST_HELD;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = sat_inc_cnt(cnt_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        level_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
`ifdef BTN_AUTOREPEAT_EN
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/add_sub_btn_conditioner.sv
// Conditions the add/sub board inputs: synchronizes the switches and debounces
// btnl/btnr. Auto-repeat on held buttons is enabled by defining BTN_AUTOREPEAT_EN.
module add_sub_btn_conditioner
    import add_sub_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw,
    input  logic        btnl,
    input  logic        btnr,
    output logic [15:0] sw_sync,
    output logic        btnl_level,
    output logic        btnr_level,
    output logic        btnl_press,
    output logic        btnr_press
);

    logic [15:0] sw_meta_q, sw_meta_d;
    logic [15:0] sw_sync_q, sw_sync_d;

    always_comb begin
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign sw_sync = sw_sync_q;

    // Channel 0 is btnl (clear), channel 1 is btnr (subtract).
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;

    assign btn_raw = {btnr, btnl};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (btn_raw[gi]),
            .level   (btn_level[gi]),
            .press   (btn_press[gi])
        );
    end

    assign btnl_level = btn_level[0];
    assign btnr_level = btn_level[1];
    assign btnl_press = btn_press[0];
    assign btnr_press = btn_press[1];

endmodule
